// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the pipelined RV32 ALU control decoder.
// ALU operation codes are kept 5 bits wide internally and sized to CTRL_W at the port.
package alu_ctrl_pkg;

  localparam int CODE_W = 5;

  localparam logic [CODE_W-1:0] ALU_AND  = 5'b00000;
  localparam logic [CODE_W-1:0] ALU_OR   = 5'b00001;
  localparam logic [CODE_W-1:0] ALU_ADD  = 5'b00010;
  localparam logic [CODE_W-1:0] ALU_SLL  = 5'b00011;
  localparam logic [CODE_W-1:0] ALU_SLT  = 5'b00100;
  localparam logic [CODE_W-1:0] ALU_SLTU = 5'b00101;
  localparam logic [CODE_W-1:0] ALU_SUB  = 5'b00110;
  localparam logic [CODE_W-1:0] ALU_XOR  = 5'b00111;
  localparam logic [CODE_W-1:0] ALU_SRL  = 5'b01000;
  localparam logic [CODE_W-1:0] ALU_SRA  = 5'b01001;
  // MUL..REMU occupy 10000..10111 in func3 order.
  localparam logic [1:0] ALU_M_PREFIX = 2'b10;

  typedef enum logic [1:0] {
    OP_LDST = 2'b00,
    OP_BR   = 2'b01,
    OP_R    = 2'b10,
    OP_I    = 2'b11
  } alu_op_e;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  function automatic logic [CODE_W-1:0] base_code(input logic [2:0] f3);
    logic [CODE_W-1:0] c;
    c = ALU_ADD;
    case (f3)
      3'b000:  c = ALU_ADD;
      3'b001:  c = ALU_SLL;
      3'b010:  c = ALU_SLT;
      3'b011:  c = ALU_SLTU;
      3'b100:  c = ALU_XOR;
      3'b101:  c = ALU_SRL;
      3'b110:  c = ALU_OR;
      default: c = ALU_AND;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational decode of {ALU_Op, func7, func3} into an ALU operation code.
// Unsupported encodings report illegal and fall back to the ADD code.
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 0,
  parameter int CTRL_W   = 4
) (
  input  logic [1:0]        alu_op,
  input  logic [6:0]        func7,
  input  logic [2:0]        func3,
  output logic [CTRL_W-1:0] code,
  output logic              illegal
);

  if (CTRL_W < 4) begin : g_bad_width
    $error("alu_ctrl_decode: CTRL_W must be at least 4");
  end
  if (ENABLE_M != 0 && CTRL_W < 5) begin : g_bad_m_width
    $error("alu_ctrl_decode: CTRL_W must be at least 5 when ENABLE_M=1");
  end

  logic [CODE_W-1:0] raw_code;
  logic              raw_illegal;

  always_comb begin
    raw_code    = ALU_ADD;
    raw_illegal = 1'b0;
    case (alu_op_e'(alu_op))
      OP_LDST: raw_code = ALU_ADD;
      OP_BR: begin
        case (func3)
          3'b000, 3'b001: raw_code = ALU_SUB;
          3'b100, 3'b101: raw_code = ALU_SLT;
          3'b110, 3'b111: raw_code = ALU_SLTU;
          default:        raw_illegal = 1'b1;
        endcase
      end
      OP_R: begin
        if (func7 == F7_BASE) begin
          raw_code = base_code(func3);
        end else if (func7 == F7_ALT && func3 == 3'b000) begin
          raw_code = ALU_SUB;
        end else if (func7 == F7_ALT && func3 == 3'b101) begin
          raw_code = ALU_SRA;
        end else if (func7 == F7_MULDIV && ENABLE_M != 0) begin
          raw_code = {ALU_M_PREFIX, func3};
        end else begin
          raw_illegal = 1'b1;
        end
      end
      default: begin
        // I-type: func7 only qualifies the shift immediates.
        case (func3)
          3'b000: raw_code = ALU_ADD;
          3'b001: begin
            if (func7 == F7_BASE) raw_code = ALU_SLL;
            else                  raw_illegal = 1'b1;
          end
          3'b101: begin
            if (func7 == F7_BASE)     raw_code = ALU_SRL;
            else if (func7 == F7_ALT) raw_code = ALU_SRA;
            else                      raw_illegal = 1'b1;
          end
          default: raw_code = base_code(func3);
        endcase
      end
    endcase
    if (raw_illegal) raw_code = ALU_ADD;
  end

  assign code    = CTRL_W'(raw_code);
  assign illegal = raw_illegal;

endmodule

// File: rtl/alu_control_pipe.sv
// ALU control decoder registered behind a valid/ready handshake with a skid entry.
// in_ready depends only on registered state, so out_ready never reaches it combinationally.
module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int ENABLE_M = 0,
  parameter int CTRL_W   = 4,
  parameter int TAG_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALU_Op,
  input  logic [6:0]        func7,
  input  logic [2:0]        func3,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALU_control_out,
  output logic              out_illegal,
  output logic [TAG_W-1:0]  out_tag
);

  if (TAG_W < 1) begin : g_bad_tag
    $error("alu_control_pipe: TAG_W must be at least 1");
  end

  logic [CTRL_W-1:0] dec_code;
  logic              dec_illegal;

  alu_ctrl_decode #(
    .ENABLE_M (ENABLE_M),
    .CTRL_W   (CTRL_W)
  ) u_decode (
    .alu_op  (ALU_Op),
    .func7   (func7),
    .func3   (func3),
    .code    (dec_code),
    .illegal (dec_illegal)
  );

  logic              main_valid_q, main_valid_d;
  logic [CTRL_W-1:0] main_code_q,  main_code_d;
  logic              main_ill_q,   main_ill_d;
  logic [TAG_W-1:0]  main_tag_q,   main_tag_d;
  logic              skid_valid_q, skid_valid_d;
  logic [CTRL_W-1:0] skid_code_q,  skid_code_d;
  logic              skid_ill_q,   skid_ill_d;
  logic [TAG_W-1:0]  skid_tag_q,   skid_tag_d;

  logic accept;
  logic drain;

  assign in_ready = rst_n && !skid_valid_q;
  assign accept   = in_valid && in_ready;
  assign drain    = main_valid_q && out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_code_d  = main_code_q;
    main_ill_d   = main_ill_q;
    main_tag_d   = main_tag_q;
    skid_valid_d = skid_valid_q;
    skid_code_d  = skid_code_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // in_ready is low here, so only the skid-to-main move can happen.
      if (drain) begin
        main_valid_d = 1'b1;
        main_code_d  = skid_code_q;
        main_ill_d   = skid_ill_q;
        main_tag_d   = skid_tag_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept) begin
      if (!main_valid_q || drain) begin
        main_valid_d = 1'b1;
        main_code_d  = dec_code;
        main_ill_d   = dec_illegal;
        main_tag_d   = in_tag;
      end else begin
        skid_valid_d = 1'b1;
        skid_code_d  = dec_code;
        skid_ill_d   = dec_illegal;
        skid_tag_d   = in_tag;
      end
    end else if (drain) begin
      main_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_code_q  <= '0;
      main_ill_q   <= 1'b0;
      main_tag_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_code_q  <= '0;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_code_q  <= main_code_d;
      main_ill_q   <= main_ill_d;
      main_tag_q   <= main_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_code_q  <= skid_code_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
    end
  end

  assign out_valid       = main_valid_q;
  assign ALU_control_out = main_code_q;
  assign out_illegal     = main_ill_q;
  assign out_tag         = main_tag_q;

endmodule

// File: tb/tb_alu_control_pipe.sv
// Directed bench for alu_control_pipe: one base instance and one with the M extension,
// both driven from the same stimulus.
module tb_alu_control_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush;
  logic       in_valid;
  logic [1:0] alu_op;
  logic [6:0] func7;
  logic [2:0] func3;
  logic [7:0] in_tag;
  logic       out_ready;

  logic       in_ready0, out_valid0, out_illegal0;
  logic [3:0] code0;
  logic [7:0] out_tag0;
  logic       in_ready1, out_valid1, out_illegal1;
  logic [4:0] code1;
  logic [7:0] out_tag1;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] tag_ctr = 8'h40;

  always #5 clk = ~clk;

  alu_control_pipe #(.ENABLE_M(0), .CTRL_W(4), .TAG_W(8)) dut0 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready0),
    .ALU_Op(alu_op), .func7(func7), .func3(func3), .in_tag(in_tag),
    .out_valid(out_valid0), .out_ready(out_ready), .ALU_control_out(code0),
    .out_illegal(out_illegal0), .out_tag(out_tag0)
  );

  alu_control_pipe #(.ENABLE_M(1), .CTRL_W(5), .TAG_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .ALU_Op(alu_op), .func7(func7), .func3(func3), .in_tag(in_tag),
    .out_valid(out_valid1), .out_ready(out_ready), .ALU_control_out(code1),
    .out_illegal(out_illegal1), .out_tag(out_tag1)
  );

  always @(posedge clk) begin
    if (rst_n && !flush && out_valid0 && out_ready)
      $display("xfer tag=%02h code=%02h illegal=%0b", out_tag0, code0, out_illegal0);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [6:0] f7,
                       input logic [2:0] f3, input logic [7:0] t);
    in_valid = v;
    alu_op   = op;
    func7    = f7;
    func3    = f3;
    in_tag   = t;
  endtask

  // Single request with out_ready high; result is visible one edge later on both instances.
  task automatic dec(input string name, input logic [1:0] op, input logic [6:0] f7,
                     input logic [2:0] f3, input logic [4:0] exp_code, input logic exp_ill);
    tag_ctr = tag_ctr + 8'd1;
    drive(1'b1, op, f7, f3, tag_ctr);
    step();
    chk({name, ".code"}, 32'(code0), 32'(exp_code));
    chk({name, ".ill"}, 32'(out_illegal0), 32'(exp_ill));
    chk({name, ".tag"}, 32'(out_tag0), 32'(tag_ctr));
    chk({name, ".code_m"}, 32'(code1), 32'(exp_code));
    in_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 2'b00, 7'h00, 3'b000, 8'h00);
    step(); step();
    chk("rst.out_valid", 32'(out_valid0), 0);
    chk("rst.code", 32'(code0), 0);
    chk("rst.illegal", 32'(out_illegal0), 0);
    chk("rst.tag", 32'(out_tag0), 0);
    chk("rst.in_ready", 32'(in_ready0), 0);
    rst_n = 1'b1;
    #1;
    chk("rst.in_ready_after", 32'(in_ready0), 1);

    // ld/st back-to-back, func fields must be ignored
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b00, 7'h55, 3'(i + 5), 8'(8'h10 + i));
      step();
      chk("ldst.valid", 32'(out_valid0), 1);
      chk("ldst.tag", 32'(out_tag0), 32'(8'h10 + i));
      chk("ldst.code", 32'(code0), 32'h2);
      chk("ldst.ill", 32'(out_illegal0), 0);
    end
    in_valid = 1'b0;
    step();
    chk("ldst.drained", 32'(out_valid0), 0);

    // decode table
    dec("r_sra",   2'b10, 7'b0100000, 3'b101, 5'b01001, 1'b0);
    dec("i_addi",  2'b11, 7'b0100000, 3'b000, 5'b00010, 1'b0);
    dec("i_slli7", 2'b11, 7'b0000001, 3'b001, 5'b00010, 1'b1);
    dec("r_and",   2'b10, 7'b0000000, 3'b111, 5'b00000, 1'b0);
    dec("r_sub",   2'b10, 7'b0100000, 3'b000, 5'b00110, 1'b0);
    dec("r_alt1",  2'b10, 7'b0100000, 3'b001, 5'b00010, 1'b1);
    dec("r_f7bad", 2'b10, 7'b1000000, 3'b000, 5'b00010, 1'b1);
    dec("br_010",  2'b01, 7'b0000000, 3'b010, 5'b00010, 1'b1);
    dec("br_000",  2'b01, 7'b1111111, 3'b000, 5'b00110, 1'b0);
    dec("br_101",  2'b01, 7'b0000000, 3'b101, 5'b00100, 1'b0);
    dec("br_111",  2'b01, 7'b0000000, 3'b111, 5'b00101, 1'b0);
    dec("i_srli",  2'b11, 7'b0000000, 3'b101, 5'b01000, 1'b0);
    dec("i_srai",  2'b11, 7'b0100000, 3'b101, 5'b01001, 1'b0);
    dec("i_sr_bad",2'b11, 7'b0000001, 3'b101, 5'b00010, 1'b1);
    dec("i_xori",  2'b11, 7'b1111111, 3'b100, 5'b00111, 1'b0);
    dec("i_slli",  2'b11, 7'b0000000, 3'b001, 5'b00011, 1'b0);

    // M extension: base instance flags illegal, M instance decodes DIV
    drive(1'b1, 2'b10, 7'b0000001, 3'b100, 8'h77);
    step();
    chk("m.off_ill", 32'(out_illegal0), 1);
    chk("m.off_code", 32'(code0), 32'h2);
    chk("m.on_ill", 32'(out_illegal1), 0);
    chk("m.on_code", 32'(code1), 32'h14);
    chk("m.on_tag", 32'(out_tag1), 32'h77);
    in_valid = 1'b0;
    step();
    chk("m.drained", 32'(out_valid0), 0);

    // backpressure: tag1 in main, tag2 in skid, tag3 must wait
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 7'h00, 3'b000, 8'h01);
    step();
    chk("bp.valid1", 32'(out_valid0), 1);
    chk("bp.tag1", 32'(out_tag0), 1);
    chk("bp.ready1", 32'(in_ready0), 1);
    drive(1'b1, 2'b10, 7'b0100000, 3'b000, 8'h02);
    step();
    chk("bp.ready2", 32'(in_ready0), 0);
    chk("bp.hold_tag", 32'(out_tag0), 1);
    chk("bp.hold_code", 32'(code0), 32'h2);
    drive(1'b1, 2'b00, 7'h00, 3'b000, 8'h03);
    step();
    chk("bp.stall_tag", 32'(out_tag0), 1);
    chk("bp.stall_ready", 32'(in_ready0), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step();
    chk("bp.tag2", 32'(out_tag0), 2);
    chk("bp.code2", 32'(code0), 32'h6);
    chk("bp.valid2", 32'(out_valid0), 1);
    chk("bp.ready3", 32'(in_ready0), 1);
    step();
    chk("bp.empty", 32'(out_valid0), 0);

    // flush with both entries full and a request pending
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 7'h00, 3'b000, 8'h21);
    step();
    drive(1'b1, 2'b00, 7'h00, 3'b000, 8'h22);
    step();
    chk("fl.skid_full", 32'(in_ready0), 0);
    drive(1'b1, 2'b00, 7'h00, 3'b000, 8'h23);
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl.valid", 32'(out_valid0), 0);
    chk("fl.ready", 32'(in_ready0), 1);
    out_ready = 1'b1;
    step();
    chk("fl.no_stale", 32'(out_valid0), 0);

    // flush while a request would otherwise be accepted
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 7'h00, 3'b000, 8'h24);
    step();
    drive(1'b1, 2'b00, 7'h00, 3'b000, 8'h25);
    flush = 1'b1;
    #1;
    chk("fl2.ready_during", 32'(in_ready0), 1);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl2.valid", 32'(out_valid0), 0);
    out_ready = 1'b1;
    step();
    chk("fl2.no_stale", 32'(out_valid0), 0);

    // reset with the skid full
    out_ready = 1'b0;
    drive(1'b1, 2'b00, 7'h00, 3'b000, 8'h31);
    step();
    drive(1'b1, 2'b11, 7'h00, 3'b100, 8'h32);
    step();
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rs.ready_low", 32'(in_ready0), 0);
    step();
    chk("rs.valid", 32'(out_valid0), 0);
    chk("rs.code", 32'(code0), 0);
    chk("rs.tag", 32'(out_tag0), 0);
    chk("rs.ill", 32'(out_illegal0), 0);
    chk("rs.ready_in", 32'(in_ready0), 0);
    rst_n = 1'b1;
    #1;
    chk("rs.ready_after", 32'(in_ready0), 1);
    out_ready = 1'b1;
    step();
    chk("rs.no_stale1", 32'(out_valid0), 0);
    step();
    chk("rs.no_stale2", 32'(out_valid0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
